// File: rtl/mem_arb_pkg.sv
// Shared constants, owner index type and round-robin helper
// for the memory port arbiter.
package mem_arb_pkg;

   localparam int NREQ_DEF = 3;
   localparam int AW_DEF   = 11;
   localparam int DW_DEF   = 32;
   localparam int NMAX     = 8;
   localparam int OW       = $clog2(NREQ_DEF);

   typedef logic [OW-1:0]   owner_t;
   typedef logic [NMAX-1:0] vec_t;

   // One-hot of the first set bit of v scanning ptr, ptr+1, ... mod n.
   function automatic vec_t rr_first(
      input vec_t v,
      input int   ptr,
      input int   n
   );
      vec_t oh;
      int   idx;
      oh = '0;
      for (int k = 0; k < NMAX; k++) begin
         idx = ptr + k;
         if (idx >= n) begin
            idx = idx - n;
         end
         if (k < n && oh == '0 && v[idx[2:0]]) begin
            oh[idx[2:0]] = 1'b1;
         end
      end
      return oh;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin picker: request vector plus start pointer
// gives a one-hot winner, its index and a valid flag.
module rr_picker
   import mem_arb_pkg::*;
#(
   parameter  int NREQ = NREQ_DEF,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] vec_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] oh_o,
   output logic [IW-1:0]   idx_o,
   output logic            vld_o
);

   vec_t pad;
   vec_t pick;

   always_comb begin
      pad = '0;
      pad[NREQ-1:0] = vec_i;
      pick  = rr_first(pad, int'(ptr_i), NREQ);
      oh_o  = pick[NREQ-1:0];
      vld_o = |pick;
   end

   always_comb begin
      idx_o = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh_o[i]) begin
            idx_o = IW'(i);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a 2-read/1-write memory among NREQ requesters and
// routes registered read data back to the owning requester.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [NREQ*DW-1:0] rdata,
   output logic               mem_w_en,
   output logic [AW-1:0]      mem_w_adrs,
   output logic [DW-1:0]      mem_data_in,
   output logic               mem_r_en1,
   output logic [AW-1:0]      mem_r_adrs1,
   output logic               mem_r_en2,
   output logic [AW-1:0]      mem_r_adrs2,
   input  logic [DW-1:0]      mem_data_out1,
   input  logic [DW-1:0]      mem_data_out2
);

   localparam int IW = $clog2(NREQ);

   logic [IW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [IW-1:0]      rd_ptr_q, rd_ptr_d;
   logic               v1_q, v1_d;
   logic               v2_q, v2_d;
   logic [IW-1:0]      o1_q, o1_d;
   logic [IW-1:0]      o2_q, o2_d;
   logic [NREQ*DW-1:0] rdata_q;

   logic [NREQ-1:0] w_cand, w_oh;
   logic [NREQ-1:0] r_cand, r2_cand;
   logic [NREQ-1:0] r1_oh, r2_oh;
   logic [IW-1:0]   w_idx, r1_idx, r2_idx;
   logic            w_vld, r1_vld, r2_vld;
   logic [AW-1:0]   w_addr, r1_addr, r2_addr;
   logic [DW-1:0]   w_data;

   function automatic logic [IW-1:0] inc(
      input logic [IW-1:0] i
   );
      return (int'(i) == NREQ - 1) ? '0 : i + IW'(1);
   endfunction

   assign w_cand = req & req_we;

   rr_picker #(.NREQ(NREQ)) u_wr_pick (
      .vec_i (w_cand),
      .ptr_i (wr_ptr_q),
      .oh_o  (w_oh),
      .idx_o (w_idx),
      .vld_o (w_vld)
   );

   always_comb begin
      w_addr = '0;
      w_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_oh[i]) begin
            w_addr = req_addr[i*AW +: AW];
            w_data = req_wdata[i*DW +: DW];
         end
      end
   end

   // A read hitting this cycle's write address waits one cycle
   // so it observes the freshly written data.
   always_comb begin
      r_cand = '0;
      for (int i = 0; i < NREQ; i++) begin
         r_cand[i] = req[i] & ~req_we[i]
                   & ~(w_vld & (req_addr[i*AW +: AW] == w_addr));
      end
   end

   rr_picker #(.NREQ(NREQ)) u_rd_pick1 (
      .vec_i (r_cand),
      .ptr_i (rd_ptr_q),
      .oh_o  (r1_oh),
      .idx_o (r1_idx),
      .vld_o (r1_vld)
   );

   assign r2_cand = r_cand & ~r1_oh;

   rr_picker #(.NREQ(NREQ)) u_rd_pick2 (
      .vec_i (r2_cand),
      .ptr_i (rd_ptr_q),
      .oh_o  (r2_oh),
      .idx_o (r2_idx),
      .vld_o (r2_vld)
   );

   always_comb begin
      r1_addr = '0;
      r2_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r1_oh[i]) begin
            r1_addr = req_addr[i*AW +: AW];
         end
         if (r2_oh[i]) begin
            r2_addr = req_addr[i*AW +: AW];
         end
      end
   end

   always_comb begin
      gnt         = '0;
      mem_w_en    = 1'b0;
      mem_w_adrs  = '0;
      mem_data_in = '0;
      mem_r_en1   = 1'b0;
      mem_r_adrs1 = '0;
      mem_r_en2   = 1'b0;
      mem_r_adrs2 = '0;
      if (resetn) begin
         gnt         = w_oh | r1_oh | r2_oh;
         mem_w_en    = w_vld;
         mem_w_adrs  = w_addr;
         mem_data_in = w_data;
         mem_r_en1   = r1_vld;
         mem_r_adrs1 = r1_addr;
         mem_r_en2   = r2_vld;
         mem_r_adrs2 = r2_addr;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (w_vld) begin
         wr_ptr_d = inc(w_idx);
      end
      if (r2_vld) begin
         rd_ptr_d = inc(r2_idx);
      end else if (r1_vld) begin
         rd_ptr_d = inc(r1_idx);
      end
      v1_d = r1_vld;
      o1_d = r1_idx;
      v2_d = r2_vld;
      o2_d = r2_idx;
   end

   always_comb begin
      rvalid = '0;
      rdata  = rdata_q;
      for (int i = 0; i < NREQ; i++) begin
         if (v1_q && int'(o1_q) == i) begin
            rvalid[i]         = 1'b1;
            rdata[i*DW +: DW] = mem_data_out1;
         end
         if (v2_q && int'(o2_q) == i) begin
            rvalid[i]         = 1'b1;
            rdata[i*DW +: DW] = mem_data_out2;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         o1_q     <= '0;
         o2_q     <= '0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         o1_q     <= o1_d;
         o2_q     <= o2_d;
         rdata_q  <= rdata;
      end
   end

endmodule
